grad_stream_calc: RTL and testbench



---
 rtl/sift_grad_pkg.sv | 11 +
 rtl/grad_line_buf.sv | 24 ++
 rtl/grad_stream_calc.sv | 207 ++++++++++++++++++++
 tb/tb_grad_stream_calc.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sift_grad_pkg.sv
// Shared constants and helpers for the SIFT gradient stream stage.
package sift_grad_pkg;

    localparam int N_BINS = 8;
    localparam int BIN_W  = $clog2(N_BINS);

    function automatic int grad_w(input int dw);
        return dw + 1;
    endfunction

endpackage

// File: rtl/grad_line_buf.sv
// IMG_W-deep pixel delay line that shifts only when advanced.
module grad_line_buf #(
    parameter int IMG_W = 640,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          i_adv,
    input  logic [DW-1:0] i_din,
    output logic [DW-1:0] o_dout
);

    logic [DW-1:0] r_mem [IMG_W];

    always_ff @(posedge clk) begin
        if (i_adv) begin
            r_mem[0] <= i_din;
            for (int i = 1; i < IMG_W; i++)
                r_mem[i] <= r_mem[i-1];
        end
    end

    assign o_dout = r_mem[IMG_W-1];

endmodule

// File: rtl/grad_stream_calc.sv
// Streaming 3x3 central-difference gradient stage (dx, dy, |dx|+|dy|).
// Define GRAD_ORI_BIN_EN to build the 8-way orientation bin output.
module grad_stream_calc
    import sift_grad_pkg::*;
#(
    parameter int DW    = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  sof,
    input  logic                  din_valid,
    input  logic [DW-1:0]         din,
    output logic [grad_w(DW)-1:0] dx,
    output logic [grad_w(DW)-1:0] dy,
    output logic [grad_w(DW)-1:0] mag,
    output logic [BIN_W-1:0]      ori_bin,
    output logic                  out_en,
    output logic                  out_eof
);

    localparam int GW = grad_w(DW);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic          w_acc;
    logic          w_take;
    logic          w_last_col;
    logic          w_last_row;
    logic          w_win;
    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          r_active;

    assign w_acc      = en & din_valid;
    assign w_take     = w_acc & (sof | r_active);
    assign w_col      = sof ? '0 : r_col;
    assign w_row      = sof ? '0 : r_row;
    assign w_last_col = (w_col == CW'(IMG_W-1));
    assign w_last_row = (w_row == RW'(IMG_H-1));
    assign w_win      = w_take & (w_row >= RW'(2)) & (w_col >= CW'(2));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col    <= '0;
            r_row    <= '0;
            r_active <= 1'b0;
        end else if (w_take) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_last_row ? '0 : w_row + 1'b1;
            end else begin
                r_col <= w_col + 1'b1;
                r_row <= w_row;
            end
            r_active <= !(w_last_col && w_last_row);
        end
    end

    logic [DW-1:0] w_l1;
    logic [DW-1:0] w_l2;

    grad_line_buf #(.IMG_W(IMG_W), .DW(DW)) u_lb1 (
        .clk    (clk),
        .i_adv  (w_take),
        .i_din  (din),
        .o_dout (w_l1)
    );

    grad_line_buf #(.IMG_W(IMG_W), .DW(DW)) u_lb2 (
        .clk    (clk),
        .i_adv  (w_take),
        .i_din  (w_l1),
        .o_dout (w_l2)
    );

    // Index 0 is the newest column; only the taps the differences need are kept.
    logic [DW-1:0] r_cur [2];
    logic [DW-1:0] r_mid [3];
    logic [DW-1:0] r_top [2];
    logic          r_win_vld;
    logic          r_win_eof;

    always_ff @(posedge clk) begin
        if (w_take) begin
            r_cur[0] <= din;
            r_cur[1] <= r_cur[0];
            r_mid[0] <= w_l1;
            r_mid[1] <= r_mid[0];
            r_mid[2] <= r_mid[1];
            r_top[0] <= w_l2;
            r_top[1] <= r_top[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_vld <= 1'b0;
            r_win_eof <= 1'b0;
        end else begin
            r_win_vld <= w_win;
            r_win_eof <= w_win & w_last_col & w_last_row;
        end
    end

    logic [GW-1:0]        w_dx;
    logic [GW-1:0]        w_dy;
    logic signed [GW-1:0] r_s1_dx;
    logic signed [GW-1:0] r_s1_dy;
    logic                 r_s1_vld;
    logic                 r_s1_eof;

    assign w_dx = {1'b0, r_mid[0]} - {1'b0, r_mid[2]};
    assign w_dy = {1'b0, r_cur[1]} - {1'b0, r_top[1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld <= 1'b0;
            r_s1_eof <= 1'b0;
            r_s1_dx  <= '0;
            r_s1_dy  <= '0;
        end else begin
            r_s1_vld <= r_win_vld;
            r_s1_eof <= r_win_eof;
            if (r_win_vld) begin
                r_s1_dx <= w_dx;
                r_s1_dy <= w_dy;
            end
        end
    end

    logic [GW-1:0]    w_adx;
    logic [GW-1:0]    w_ady;
    logic [GW-1:0]    w_mag;
    logic [BIN_W-1:0] w_bin;

    assign w_adx = r_s1_dx[GW-1] ? -r_s1_dx : r_s1_dx;
    assign w_ady = r_s1_dy[GW-1] ? -r_s1_dy : r_s1_dy;
    assign w_mag = w_adx + w_ady;

`ifdef GRAD_ORI_BIN_EN
    logic w_xp, w_xn, w_yp, w_yn, w_lt, w_gt;

    assign w_xn = r_s1_dx[GW-1];
    assign w_yn = r_s1_dy[GW-1];
    assign w_xp = !w_xn && (r_s1_dx != '0);
    assign w_yp = !w_yn && (r_s1_dy != '0);
    assign w_lt = (w_ady < w_adx);
    assign w_gt = (w_ady > w_adx);

    always_comb begin
        w_bin = '0;
        unique case (1'b1)
            (!w_yn && w_xp && w_lt):  w_bin = BIN_W'(0);
            (w_xp && w_yp && !w_lt):  w_bin = BIN_W'(1);
            (!w_xp && w_yp && w_gt):  w_bin = BIN_W'(2);
            (w_xn && w_yp && !w_gt):  w_bin = BIN_W'(3);
            (w_xn && !w_yp && w_lt):  w_bin = BIN_W'(4);
            (w_xn && w_yn && !w_lt):  w_bin = BIN_W'(5);
            (!w_xn && w_yn && w_gt):  w_bin = BIN_W'(6);
            (w_xp && w_yn && !w_gt):  w_bin = BIN_W'(7);
            default:                  w_bin = '0;
        endcase
    end
`else
    assign w_bin = '0;
`endif

    logic [GW-1:0]    r_dx;
    logic [GW-1:0]    r_dy;
    logic [GW-1:0]    r_mag;
    logic [BIN_W-1:0] r_bin;
    logic             r_out_en;
    logic             r_out_eof;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dx      <= '0;
            r_dy      <= '0;
            r_mag     <= '0;
            r_bin     <= '0;
            r_out_en  <= 1'b0;
            r_out_eof <= 1'b0;
        end else begin
            r_out_en  <= r_s1_vld;
            r_out_eof <= r_s1_vld & r_s1_eof;
            if (r_s1_vld) begin
                r_dx  <= r_s1_dx;
                r_dy  <= r_s1_dy;
                r_mag <= w_mag;
                r_bin <= w_bin;
            end
        end
    end

    assign dx      = r_dx;
    assign dy      = r_dy;
    assign mag     = r_mag;
    assign ori_bin = r_bin;
    assign out_en  = r_out_en;
    assign out_eof = r_out_eof;

endmodule

// File: tb/tb_grad_stream_calc.sv
// Scoreboard bench for grad_stream_calc on an 8x6 frame.
module tb_grad_stream_calc;

    localparam int W = 8;
    localparam int H = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       sof = 1'b0;
    logic       din_valid = 1'b0;
    logic [7:0] din = '0;
    logic [8:0] dx, dy, mag;
    logic [2:0] ori_bin;
    logic       out_en, out_eof;

    always #5 clk = ~clk;

    grad_stream_calc #(.DW(8), .IMG_W(W), .IMG_H(H)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sof       (sof),
        .din_valid (din_valid),
        .din       (din),
        .dx        (dx),
        .dy        (dy),
        .mag       (mag),
        .ori_bin   (ori_bin),
        .out_en    (out_en),
        .out_eof   (out_eof)
    );

    typedef struct {
        int dx;
        int dy;
        int mag;
        int bin;
        bit eof;
        int acc;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_out = 0;
    bit   mon_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (out_en) begin
                n_out++;
                if (q.size() == 0) begin
                    check("spurious_out_en", 1, 0);
                end else begin
                    m_e = q.pop_front();
                    check("dx", $signed(dx), m_e.dx);
                    check("dy", $signed(dy), m_e.dy);
                    check("mag", int'(mag), m_e.mag);
                    check("ori_bin", int'(ori_bin), m_e.bin);
                    check("out_eof", int'(out_eof), int'(m_e.eof));
                    check("latency", cyc, m_e.acc + 2);
                end
            end else begin
                check("eof_idle", int'(out_eof), 0);
            end
        end
    end

    function automatic int pix(input int mode, input int r, input int c);
        case (mode)
            0: return 50;
            1: return 10 * c;
            2: return 10 * r;
            3: return 250 - 10 * r;
            4: return 10 * (r + c);
            default: return (r == 2 && c == 3) ? 255 : 0;
        endcase
    endfunction

    function automatic exp_t hand(input int mode, input int cr, input int cc);
        exp_t e;
        e.dx = 0; e.dy = 0; e.mag = 0; e.bin = 0;
        case (mode)
            1: begin e.dx = 20; e.mag = 20; end
            2: begin e.dy = 20; e.mag = 20; e.bin = 2; end
            3: begin e.dy = -20; e.mag = 20; e.bin = 6; end
            4: begin e.dx = 20; e.dy = 20; e.mag = 40; e.bin = 1; end
            5: begin
                if (cr == 2 && cc == 2) begin e.dx = 255; e.mag = 255; e.bin = 0; end
                if (cr == 2 && cc == 4) begin e.dx = -255; e.mag = 255; e.bin = 4; end
                if (cr == 1 && cc == 3) begin e.dy = 255; e.mag = 255; e.bin = 2; end
                if (cr == 3 && cc == 3) begin e.dy = -255; e.mag = 255; e.bin = 6; end
            end
            default: ;
        endcase
`ifndef GRAD_ORI_BIN_EN
        e.bin = 0;
`endif
        e.eof = (cr == H - 2 && cc == W - 2);
        e.acc = 0;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int mode, input int r, input int c);
        exp_t e;
        en = 1'b1;
        din_valid = 1'b1;
        sof = (r == 0 && c == 0);
        din = 8'(pix(mode, r, c));
        if (r >= 2 && c >= 2) begin
            e = hand(mode, r - 1, c - 1);
            e.acc = cyc + 1;
            q.push_back(e);
        end
        tick();
    endtask

    task automatic idle(input int n);
        en = 1'b1;
        din_valid = 1'b0;
        sof = 1'b0;
        repeat (n) tick();
    endtask

    task automatic run_frame(input int mode, input bit do_stall, input bit do_rst);
        int base;
        base = n_out;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (do_stall && r == 3 && c == 4) begin
                    en = 1'b0;
                    din_valid = 1'b1;
                    sof = 1'b0;
                    din = 8'hAA;
                    repeat (5) tick();
                end
                if (do_rst && r == 3 && c == 4) begin
                    en = 1'b1;
                    din_valid = 1'b1;
                    sof = 1'b0;
                    din = 8'(pix(mode, r, c));
                    rst = 1'b1;
                    tick();
                    rst = 1'b0;
                    din_valid = 1'b0;
                    q.delete();
                    check("rst_out_en", int'(out_en), 0);
                    check("rst_dx", int'(dx), 0);
                    check("rst_mag", int'(mag), 0);
                    return;
                end
                send(mode, r, c);
            end
        end
        din_valid = 1'b0;
        sof = 1'b0;
        for (int i = 0; i < 20 && q.size() != 0; i++) tick();
        check("drain", q.size(), 0);
        idle(4);
        check("frame_count", n_out - base, (W - 2) * (H - 2));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_out_en", int'(out_en), 0);
        check("reset_out_eof", int'(out_eof), 0);
        check("reset_dx", int'(dx), 0);
        check("reset_dy", int'(dy), 0);
        check("reset_mag", int'(mag), 0);
        check("reset_bin", int'(ori_bin), 0);
        mon_on = 1'b1;

        en = 1'b1;
        din_valid = 1'b1;
        sof = 1'b0;
        for (int i = 0; i < 12; i++) begin
            din = 8'(i * 17);
            tick();
        end
        idle(4);
        check("pre_sof_outputs", n_out, 0);

        run_frame(0, 1'b0, 1'b0);
        run_frame(1, 1'b0, 1'b0);
        run_frame(2, 1'b0, 1'b0);
        run_frame(3, 1'b0, 1'b0);
        run_frame(5, 1'b0, 1'b0);
        run_frame(4, 1'b0, 1'b0);
        run_frame(1, 1'b1, 1'b0);
        run_frame(1, 1'b0, 1'b1);
        idle(3);
        run_frame(4, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
